// File: rtl/runway_n_if.sv
`default_nettype none
// ============================================================================
// Module      : runway_n_if
// Description : Switch/LED bundle between the board wrapper and the
//               runway_n light sequencer.
//                 sw   - 2-bit wind mode select (wrapper -> sequencer)
//                 ledr - N_LEDS light pattern, bit 0 = rightmost LED
//                 step - one-cycle pulse in the cycle ledr takes a new value
//               master modport: board/wrapper side; slave modport: sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface runway_n_if #(
    parameter int N_LEDS = 3
);
    logic [1:0]        sw;
    logic [N_LEDS-1:0] ledr;
    logic              step;

    modport master (
        output sw,
        input  ledr,
        input  step
    );

    modport slave (
        input  sw,
        output ledr,
        output step
    );
endinterface : runway_n_if
`default_nettype wire

// File: rtl/runway_n.sv
`default_nettype none
// ============================================================================
// Module      : runway_n
// Description : Parametrised runway-light sequencer. A prescaler divides clk
//               by STEP_DIV; on every step edge the LED pattern advances
//               according to the wind switch:
//                 00 calm (alternating even/odd bits)
//                 01 single LED running right-to-left
//                 10 single LED running left-to-right
//                 11 hold, or ping-pong bounce when RUNWAY_BOUNCE_EN is defined
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-low reset
//               bus   - runway_n_if.slave (sw in, ledr/step out)
// Parameters  : N_LEDS (>= 3), STEP_DIV (>= 1)
// Macro       : RUNWAY_BOUNCE_EN - enables bounce mode on sw=11
// Revision    : 1.0 - initial release
// ============================================================================
module runway_n #(
    parameter int N_LEDS   = 3,
    parameter int STEP_DIV = 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    runway_n_if.slave   bus
);

    localparam int c_CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(STEP_DIV - 1);

    // Even-index bits lit: 101 for three LEDs, 0x55 for eight.
    function automatic logic [N_LEDS-1:0] f_calm_a();
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < N_LEDS; i += 2) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [N_LEDS-1:0] c_CALM_A = f_calm_a();
    localparam logic [N_LEDS-1:0] c_CALM_B = ~c_CALM_A;
    localparam logic [N_LEDS-1:0] c_BIT0   = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] c_BITN   = c_BIT0 << (N_LEDS - 1);

    logic [c_CW-1:0]   cnt_q,  cnt_d;
    logic [N_LEDS-1:0] ledr_q, ledr_d;
    logic              step_q;
    logic              w_step_edge;
    logic              w_onehot;

`ifdef RUNWAY_BOUNCE_EN
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    dir_t dir_q, dir_d;
`endif

    assign w_step_edge = (cnt_q == c_LAST);
    assign w_onehot    = $onehot(ledr_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            ledr_q <= c_CALM_A;
            step_q <= 1'b0;
`ifdef RUNWAY_BOUNCE_EN
            dir_q  <= DIR_LEFT;
`endif
        end else begin
            cnt_q  <= cnt_d;
            ledr_q <= ledr_d;
            step_q <= w_step_edge;
`ifdef RUNWAY_BOUNCE_EN
            dir_q  <= dir_d;
`endif
        end
    end

    always_comb begin
        // Prescaler free-runs; mode changes never disturb it.
        cnt_d  = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
        ledr_d = ledr_q;
`ifdef RUNWAY_BOUNCE_EN
        dir_d  = dir_q;
`endif
        if (w_step_edge) begin
            case (bus.sw)
                2'b00: ledr_d = (ledr_q == c_CALM_A) ? c_CALM_B : c_CALM_A;
                2'b01: ledr_d = w_onehot ? {ledr_q[N_LEDS-2:0], ledr_q[N_LEDS-1]} : c_BIT0;
                2'b10: ledr_d = w_onehot ? {ledr_q[0], ledr_q[N_LEDS-1:1]} : c_BITN;
                default: begin
`ifdef RUNWAY_BOUNCE_EN
                    // Endpoints turn around immediately so each is lit one step.
                    if (!w_onehot) begin
                        ledr_d = c_BIT0;
                        dir_d  = DIR_LEFT;
                    end else if (dir_q == DIR_LEFT) begin
                        if (ledr_q[N_LEDS-1]) begin
                            ledr_d = c_BITN >> 1;
                            dir_d  = DIR_RIGHT;
                        end else begin
                            ledr_d = ledr_q << 1;
                        end
                    end else begin
                        if (ledr_q[0]) begin
                            ledr_d = c_BIT0 << 1;
                            dir_d  = DIR_LEFT;
                        end else begin
                            ledr_d = ledr_q >> 1;
                        end
                    end
`else
                    ledr_d = ledr_q;
`endif
                end
            endcase
        end
    end

    assign bus.ledr = ledr_q;
    assign bus.step = step_q;

endmodule : runway_n
`default_nettype wire

// File: doc/runway_n.md
Name: runway_n

Overview:
Parametrised runway-light sequencer driving N_LEDS board LEDs from a 2-bit wind switch.
- Generalises the fixed 3-LED runway block to any width.
- Adds a programmable step prescaler, a hold mode and an optional bounce mode.
- Sits between the switch inputs and the LEDR outputs in the top-level board wrapper.

Parameters:
N_LEDS, 3, number of LEDs in the runway; legal range >= 3.
STEP_DIV, 1, clock cycles per pattern step; legal range >= 1. Counter width is max(1, $clog2(STEP_DIV)).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0), released synchronously by board logic
sw  input  2  wind mode select, sampled every clk
ledr  output  N_LEDS  light pattern; bit 0 = rightmost LED
step  output  1  registered pulse, high for one cycle in the same cycle ledr takes a new value

Behaviour:
- Constants:
  - CALM_A = all even-index bits set (N=3: 101; N=8: 0x55).
  - CALM_B = ~CALM_A (N=3: 010; N=8: 0xAA).
- Reset (reset==0, immediate, no clock needed):
  - ledr = CALM_A, step = 0.
  - Prescaler count = 0, direction flag = LEFT.
- Prescaler:
  - Counts 0..STEP_DIV-1 every clk, then wraps.
  - A step occurs on the clk edge where count == STEP_DIV-1.
  - STEP_DIV=1: a step occurs every cycle.
  - Mode changes do not reset the count.
- On a step, ledr updates according to sw sampled at that edge:
  - sw=00 calm: ledr==CALM_A -> CALM_B; any other value -> CALM_A.
  - sw=01 right-to-left:
    - If ledr is one-hot, rotate left by 1; bit N-1 wraps to bit 0.
    - If ledr is not one-hot (includes calm patterns and 0), load bit 0 only.
  - sw=10 left-to-right:
    - If ledr is one-hot, rotate right by 1; bit 0 wraps to bit N-1.
    - If ledr is not one-hot, load bit N-1 only.
  - sw=11: hold (ledr unchanged) unless RUNWAY_BOUNCE_EN is defined. step still pulses.
- Between steps ledr holds its value. A sw change takes effect at the next step, not earlier.
- step = 1 in the cycle following each step edge (registered with ledr), otherwise 0.
- Reset asserted mid-sequence: ledr returns to CALM_A at once. After release, the first step occurs STEP_DIV cycles later.
- ledr never shows more than one lit LED in modes 01/10/11-bounce once the first step in that mode has occurred.

Optional Feature:
Macro RUNWAY_BOUNCE_EN.
- Defined: sw=11 selects bounce mode, a single LED ping-pongs using the direction flag.
  - Non-one-hot ledr: load bit 0, dir=LEFT.
  - One-hot, dir=LEFT, not at bit N-1: shift left.
  - At bit N-1 with dir=LEFT: move to bit N-2, dir=RIGHT.
  - One-hot, dir=RIGHT, not at bit 0: shift right.
  - At bit 0 with dir=RIGHT: move to bit 1, dir=LEFT.
  - Endpoints are lit exactly one step each.
  - The direction flag is left unchanged by other modes.
- Not defined: sw=11 holds ledr. The direction flag and its logic are absent.

Test Plan:
- N=3, DIV=1: reset low, then high with sw=00 for 4 clocks -> ledr 101 at reset, then 010, 101, 010, 101. step high each cycle after the first edge.
- N=3, DIV=1, from ledr=101, sw=01 for 5 steps -> 001, 010, 100, 001, 010. Then sw=10 for 4 steps -> 001, 100, 010, 001.
- N=8, DIV=4, sw=00 -> ledr alternates 0x55/0xAA, changing only every 4th clock. step high 1 of every 4 cycles. sw toggled mid-interval has no effect until the next step.
- N=8, DIV=1, sw=11 without macro -> ledr frozen at its current value for 6 cycles while step still pulses. With RUNWAY_BOUNCE_EN from 0x55 -> 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02 (0x80 and 0x01 each shown once).
- N=3, DIV=1, sw=01 running at ledr=100, assert reset low mid-cycle -> ledr=101 asynchronously before the next edge. After release, the first step gives 001.
- N=3, DIV=1: sw=10 from ledr=010 (calm pattern is not one-hot? no, it is one-hot) -> 001. From 101 (not one-hot) -> 100.
